mc_next_state_ctrl: RTL and testbench

Control unit for the multi-cycle MIPS core. Each instruction runs as a sequence of 3-bit FSM states. This block turns the current state and the latched opcode into the next state and the per-cycle control enables. It sits directly upstream of the FSM state register: it drives that register's next-state input and reads its registered current-state output back. It also owns the opcode latch, the sticky halt/illegal flags and a retired-instruction counter.

---
 rtl/mc_next_state_ctrl_pkg.sv | 39 +++
 rtl/mc_next_state_ctrl_decode.sv | 110 +++++++++++
 rtl/mc_next_state_ctrl.sv | 102 ++++++++++
 tb/tb_mc_next_state_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mc_next_state_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes,
// ALU operations and PC source selects. Used by the controller, state register, datapath and bench.
package mc_next_state_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF         = 3'b000,
    S_ID         = 3'b001,
    S_EXE_MEMADR = 3'b010,
    S_MEM        = 3'b011,
    S_WB_LW      = 3'b100,
    S_EXE_BEQ    = 3'b101,
    S_EXE_AL     = 3'b110,
    S_WB_AL      = 3'b111
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_OR  = 3'b010,
    ALU_AND = 3'b011,
    ALU_SLT = 3'b100
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_BEQ  = 2'b01,
    PC_JUMP = 2'b10
  } pc_src_t;

endpackage

// File: rtl/mc_next_state_ctrl_decode.sv
// Combinational decode of (state, latched opcode, zero) into next state and control enables.
// Zero latency; the top level applies reset and halt overrides on top of these outputs.
module mc_ctrl_decode
  import mc_next_state_ctrl_pkg::*;
(
  input  logic [2:0] cur_state,
  input  logic [5:0] op_q,
  input  logic       zero,
  output logic [2:0] next_state,
  output logic       pc_wre,
  output logic       ir_wre,
  output logic       reg_wre,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       alu_src_b,
  output logic       reg_dst,
  output logic       db_data_src,
  output logic [1:0] pc_src,
  output logic [2:0] alu_op,
  output logic       illegal_det
);

  state_t st;
  state_t nxt;

  assign st         = state_t'(cur_state);
  assign next_state = nxt;

  always_comb begin
    nxt         = S_IF;
    pc_wre      = 1'b0;
    ir_wre      = 1'b0;
    reg_wre     = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    alu_src_b   = 1'b0;
    reg_dst     = 1'b0;
    db_data_src = 1'b0;
    pc_src      = PC_SEQ;
    alu_op      = ALU_ADD;
    illegal_det = 1'b0;

    case (st)
      S_IF: begin
        nxt    = S_ID;
        ir_wre = 1'b1;
      end
      S_ID: begin
        case (op_q)
          OP_RTYPE, OP_ADDI, OP_ORI: nxt = S_EXE_AL;
          OP_LW, OP_SW:              nxt = S_EXE_MEMADR;
          OP_BEQ:                    nxt = S_EXE_BEQ;
          OP_J: begin
            nxt    = S_IF;
            pc_wre = 1'b1;
            pc_src = PC_JUMP;
          end
          OP_HALT:                   nxt = S_ID;
          default: begin
            // Unknown opcode retires as a nop: PC+4, nothing else written.
            nxt         = S_IF;
            pc_wre      = 1'b1;
            illegal_det = 1'b1;
          end
        endcase
      end
      S_EXE_AL: begin
        nxt       = S_WB_AL;
        alu_src_b = (op_q != OP_RTYPE);
        if (op_q == OP_ORI) alu_op = ALU_OR;
      end
      S_WB_AL: begin
        nxt       = S_IF;
        reg_wre   = 1'b1;
        pc_wre    = 1'b1;
        reg_dst   = (op_q == OP_RTYPE);
        alu_src_b = (op_q != OP_RTYPE);
        if (op_q == OP_ORI) alu_op = ALU_OR;
      end
      S_EXE_MEMADR: begin
        nxt       = S_MEM;
        alu_src_b = 1'b1;
      end
      S_MEM: begin
        if (op_q == OP_LW) begin
          nxt    = S_WB_LW;
          mem_rd = 1'b1;
        end else if (op_q == OP_SW) begin
          nxt    = S_IF;
          mem_wr = 1'b1;
          pc_wre = 1'b1;
        end
      end
      S_WB_LW: begin
        nxt         = S_IF;
        reg_wre     = 1'b1;
        pc_wre      = 1'b1;
        db_data_src = 1'b1;
      end
      S_EXE_BEQ: begin
        nxt    = S_IF;
        pc_wre = 1'b1;
        alu_op = ALU_SUB;
        if (zero) pc_src = PC_BEQ;
      end
      default: nxt = S_IF;
    endcase
  end

endmodule

// File: rtl/mc_next_state_ctrl.sv
// Multi-cycle MIPS control unit: opcode latch, sticky halt/illegal flags, retired counter.
// next_state and controls are combinational from cur_state/op_q/zero; RST and halt force them.
module mc_next_state_ctrl
  import mc_next_state_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       cur_state,
  input  logic [5:0]       instr_op,
  input  logic             zero,
  output logic [2:0]       next_state,
  output logic             PCWre,
  output logic             IRWre,
  output logic             RegWre,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             ALUSrcB,
  output logic             RegDst,
  output logic             DBDataSrc,
  output logic [1:0]       PCSrc,
  output logic [2:0]       ALUOp,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  logic [5:0]       op_q;
  logic             halted_q;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;

  logic [2:0] dec_next_state;
  logic       dec_pc_wre;
  logic       dec_ir_wre;
  logic       dec_reg_wre;
  logic       dec_mem_wr;
  logic       dec_illegal;
  logic       halt_det;

  mc_ctrl_decode u_decode (
    .cur_state   (cur_state),
    .op_q        (op_q),
    .zero        (zero),
    .next_state  (dec_next_state),
    .pc_wre      (dec_pc_wre),
    .ir_wre      (dec_ir_wre),
    .reg_wre     (dec_reg_wre),
    .mem_rd      (mem_rd),
    .mem_wr      (dec_mem_wr),
    .alu_src_b   (ALUSrcB),
    .reg_dst     (RegDst),
    .db_data_src (DBDataSrc),
    .pc_src      (PCSrc),
    .alu_op      (ALUOp),
    .illegal_det (dec_illegal)
  );

  assign halt_det = (cur_state == S_ID) && (op_q == OP_HALT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q      <= OP_RTYPE;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      if (cur_state == S_IF) op_q <= instr_op;
      if (halt_det) halted_q <= 1'b1;
      if (dec_illegal) illegal_q <= 1'b1;
      // PC write marks the final state of an instruction.
      if (dec_pc_wre && !halted_q) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = dec_next_state;
    PCWre      = dec_pc_wre;
    IRWre      = dec_ir_wre;
    RegWre     = dec_reg_wre;
    mem_wr     = dec_mem_wr;
    if (RST) begin
      next_state = S_IF;
      PCWre      = 1'b0;
      IRWre      = 1'b0;
      RegWre     = 1'b0;
      mem_wr     = 1'b0;
    end else if (halted_q) begin
      next_state = cur_state;
      PCWre      = 1'b0;
      IRWre      = 1'b0;
      RegWre     = 1'b0;
      mem_wr     = 1'b0;
    end
  end

  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_next_state_ctrl.sv
// Directed bench for mc_next_state_ctrl; the bench models the negedge FSM state register.
// A second instance with a 3-bit counter observes counter wrap on the same stimulus.
module tb_mc_next_state_ctrl;
  import mc_next_state_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  cur_state;
  logic [5:0]  instr_op;
  logic        zero;
  logic [2:0]  next_state;
  logic        PCWre, IRWre, RegWre, mem_rd, mem_wr, ALUSrcB, RegDst, DBDataSrc;
  logic [1:0]  PCSrc;
  logic [2:0]  ALUOp;
  logic        halted, illegal;
  logic [31:0] retired;

  logic [2:0]  w_next_state;
  logic        w_PCWre, w_IRWre, w_RegWre, w_mem_rd, w_mem_wr, w_ALUSrcB, w_RegDst, w_DBDataSrc;
  logic [1:0]  w_PCSrc;
  logic [2:0]  w_ALUOp;
  logic        w_halted, w_illegal;
  logic [2:0]  w_retired;

  mc_next_state_ctrl #(.CNT_W(32)) dut (
    .CLK(clk), .RST(rst), .cur_state(cur_state), .instr_op(instr_op), .zero(zero),
    .next_state(next_state), .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .ALUSrcB(ALUSrcB), .RegDst(RegDst),
    .DBDataSrc(DBDataSrc), .PCSrc(PCSrc), .ALUOp(ALUOp), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  mc_next_state_ctrl #(.CNT_W(3)) dut_w (
    .CLK(clk), .RST(rst), .cur_state(cur_state), .instr_op(instr_op), .zero(zero),
    .next_state(w_next_state), .PCWre(w_PCWre), .IRWre(w_IRWre), .RegWre(w_RegWre),
    .mem_rd(w_mem_rd), .mem_wr(w_mem_wr), .ALUSrcB(w_ALUSrcB), .RegDst(w_RegDst),
    .DBDataSrc(w_DBDataSrc), .PCSrc(w_PCSrc), .ALUOp(w_ALUOp), .halted(w_halted),
    .illegal(w_illegal), .retired(w_retired)
  );

  typedef struct {
    logic [2:0] st;
    logic [5:0] op;
    logic       z;
    logic [2:0] ns;
    logic [3:0] wen;   // {PCWre, IRWre, RegWre, mem_wr}
    logic       rd;
    logic [1:0] ps;
    logic [2:0] ao;
  } vec_t;

  vec_t        tbl [17];
  int          n_vec   = 0;
  int          n_err   = 0;
  int          exp_ret = 0;
  logic [2:0]  es [8];
  logic [31:0] ret_hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Runs one instruction through the state loop, checking every state against the spec.
  task automatic exec(input logic [5:0] op, input logic z, input int n, input logic [2:0] exp_st [8]);
    logic [2:0] s;
    logic [1:0] ps;
    instr_op = op;
    zero     = z;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s  = cur_state;
      ps = (s == S_EXE_BEQ && z) ? 2'b01 : ((s == S_ID && op == OP_J) ? 2'b10 : 2'b00);
      chk("seq_state",  {29'd0, s}, {29'd0, exp_st[i]});
      chk("seq_irwre",  {31'd0, IRWre},  {31'd0, s == S_IF});
      chk("seq_regwre", {31'd0, RegWre}, {31'd0, s == S_WB_AL || s == S_WB_LW});
      chk("seq_memrd",  {31'd0, mem_rd}, {31'd0, s == S_MEM && op == OP_LW});
      chk("seq_memwr",  {31'd0, mem_wr}, {31'd0, s == S_MEM && op == OP_SW});
      chk("seq_pcwre",  {31'd0, PCWre},  {31'd0, i == n - 1});
      chk("seq_pcsrc",  {30'd0, PCSrc},  {30'd0, ps});
      cur_state = next_state;
    end
    exp_ret++;
    chk("seq_end_state", {29'd0, cur_state}, {29'd0, S_IF});
    chk("seq_retired", retired, exp_ret);
    chk("seq_retired_w", {29'd0, w_retired}, exp_ret % 8);
  endtask

  initial begin
    tbl[0]  = '{S_IF,         OP_RTYPE, 1'b0, S_ID,         4'b0100, 1'b0, 2'b00, 3'b000};
    tbl[1]  = '{S_ID,         OP_RTYPE, 1'b0, S_EXE_AL,     4'b0000, 1'b0, 2'b00, 3'b000};
    tbl[2]  = '{S_ID,         OP_ADDI,  1'b0, S_EXE_AL,     4'b0000, 1'b0, 2'b00, 3'b000};
    tbl[3]  = '{S_ID,         OP_ORI,   1'b0, S_EXE_AL,     4'b0000, 1'b0, 2'b00, 3'b000};
    tbl[4]  = '{S_ID,         OP_SW,    1'b0, S_EXE_MEMADR, 4'b0000, 1'b0, 2'b00, 3'b000};
    tbl[5]  = '{S_ID,         OP_BEQ,   1'b1, S_EXE_BEQ,    4'b0000, 1'b0, 2'b00, 3'b000};
    tbl[6]  = '{S_ID,         OP_J,     1'b0, S_IF,         4'b1000, 1'b0, 2'b10, 3'b000};
    tbl[7]  = '{S_EXE_AL,     OP_ORI,   1'b0, S_WB_AL,      4'b0000, 1'b0, 2'b00, 3'b010};
    tbl[8]  = '{S_WB_AL,      OP_ADDI,  1'b0, S_IF,         4'b1010, 1'b0, 2'b00, 3'b000};
    tbl[9]  = '{S_EXE_MEMADR, OP_SW,    1'b0, S_MEM,        4'b0000, 1'b0, 2'b00, 3'b000};
    tbl[10] = '{S_MEM,        OP_SW,    1'b0, S_IF,         4'b1001, 1'b0, 2'b00, 3'b000};
    tbl[11] = '{S_MEM,        OP_LW,    1'b0, S_WB_LW,      4'b0000, 1'b1, 2'b00, 3'b000};
    tbl[12] = '{S_WB_LW,      OP_LW,    1'b0, S_IF,         4'b1010, 1'b0, 2'b00, 3'b000};
    tbl[13] = '{S_EXE_BEQ,    OP_BEQ,   1'b1, S_IF,         4'b1000, 1'b0, 2'b01, 3'b001};
    tbl[14] = '{S_EXE_BEQ,    OP_BEQ,   1'b0, S_IF,         4'b1000, 1'b0, 2'b00, 3'b001};
    tbl[15] = '{S_ID,         6'b110011, 1'b0, S_IF,        4'b1000, 1'b0, 2'b00, 3'b000};
    tbl[16] = '{S_EXE_AL,     OP_RTYPE, 1'b0, S_WB_AL,      4'b0000, 1'b0, 2'b00, 3'b000};

    // Reset with the state register parked in a write-back state.
    rst = 1'b1; cur_state = 3'b111; instr_op = 6'd0; zero = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_next_state", {29'd0, next_state}, 32'd0);
    chk("rst_wen", {28'd0, PCWre, IRWre, RegWre, mem_wr}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    rst = 1'b0;
    cur_state = S_IF;

    es = '{S_IF, S_ID, S_EXE_MEMADR, S_MEM, S_WB_LW, S_IF, S_IF, S_IF};
    exec(OP_LW, 1'b0, 5, es);
    es = '{S_IF, S_ID, S_EXE_BEQ, S_IF, S_IF, S_IF, S_IF, S_IF};
    exec(OP_BEQ, 1'b1, 3, es);
    exec(OP_BEQ, 1'b0, 3, es);
    chk("illegal_before", {31'd0, illegal}, 32'd0);
    es = '{S_IF, S_ID, S_IF, S_IF, S_IF, S_IF, S_IF, S_IF};
    exec(6'b110011, 1'b0, 2, es);
    chk("illegal_after", {31'd0, illegal}, 32'd1);
    es = '{S_IF, S_ID, S_EXE_AL, S_WB_AL, S_IF, S_IF, S_IF, S_IF};
    exec(OP_ADDI, 1'b0, 4, es);
    es = '{S_IF, S_ID, S_EXE_MEMADR, S_MEM, S_IF, S_IF, S_IF, S_IF};
    exec(OP_SW, 1'b0, 4, es);
    es = '{S_IF, S_ID, S_IF, S_IF, S_IF, S_IF, S_IF, S_IF};
    exec(OP_J, 1'b0, 2, es);
    chk("wrap_pre", {29'd0, w_retired}, 32'd7);
    exec(OP_J, 1'b0, 2, es);
    chk("wrap_post", {29'd0, w_retired}, 32'd0);
    chk("wrap_wide", retired, 32'd8);

    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      cur_state = S_IF;
      instr_op  = tbl[k].op;
      @(negedge clk);
      cur_state = tbl[k].st;
      zero      = tbl[k].z;
      #1;
      chk("tbl_next_state", {29'd0, next_state}, {29'd0, tbl[k].ns});
      chk("tbl_wen", {28'd0, PCWre, IRWre, RegWre, mem_wr}, {28'd0, tbl[k].wen});
      chk("tbl_memrd", {31'd0, mem_rd}, {31'd0, tbl[k].rd});
      chk("tbl_pcsrc", {30'd0, PCSrc}, {30'd0, tbl[k].ps});
      chk("tbl_aluop", {29'd0, ALUOp}, {29'd0, tbl[k].ao});
    end

    // HALT: freeze in decode until reset.
    @(negedge clk);
    cur_state = S_IF;
    instr_op  = OP_HALT;
    zero      = 1'b0;
    @(negedge clk);
    chk("halt_fetch_irwre", {31'd0, IRWre}, 32'd1);
    cur_state = next_state;
    #1;
    chk("halt_enter_ns", {29'd0, next_state}, {29'd0, S_ID});
    chk("halt_enter_pcwre", {31'd0, PCWre}, 32'd0);
    @(negedge clk);
    chk("halt_set", {31'd0, halted}, 32'd1);
    chk("halt_set_w", {31'd0, w_halted}, 32'd1);
    ret_hold = retired;
    for (int i = 0; i < 10; i++) begin
      chk("halt_hold_ns", {29'd0, next_state}, {29'd0, S_ID});
      chk("halt_hold_wen", {28'd0, PCWre, IRWre, RegWre, mem_wr}, 32'd0);
      cur_state = next_state;
      @(negedge clk);
    end
    chk("halt_retired_frozen", retired, ret_hold);
    rst = 1'b1;
    @(negedge clk);
    chk("halt_rst_ns", {29'd0, next_state}, 32'd0);
    chk("halt_rst_halted", {31'd0, halted}, 32'd0);
    chk("halt_rst_illegal", {31'd0, illegal}, 32'd0);
    chk("halt_rst_retired", retired, 32'd0);
    @(negedge clk);
    chk("halt_rst_hold", {31'd0, halted}, 32'd0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
